blake2_block_ctrl: RTL
======================

Name: blake2_block_ctrl

Overview:
- Sequences the BLAKE2s compression core from the byte stream produced by the I/O interface.
- Forwards message bytes into the core's 64-byte message buffer and zero-pads the final partial block.
- Maintains the 64-bit byte counter t and issues start/first/last to the core.
- After the final compression, streams nn digest bytes back to the I/O interface.

Parameters:
- BB, 64, block size in bytes; data_idx width is log2(BB)=6.
- HB, 32, maximum digest bytes; hash index width is log2(HB)=5.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- kk_i  in  6  key length in bytes (0 = unkeyed)
- nn_i  in  6  digest length in bytes, 1..32
- ll_i  in  64  message length in bytes
- data_v_i  in  1  message byte valid
- data_i  in  8  message byte
- data_idx_i  in  6  byte position within current block
- block_first_i  in  1  current block is first of message (informational)
- block_last_i  in  1  current block is last of message
- ready_o  out  1  controller accepts bytes
- err_o  out  1  sticky: byte arrived while not ready
- msg_we_o  out  1  core message buffer byte write
- msg_idx_o  out  6  write index
- msg_byte_o  out  8  write data
- core_start_o  out  1  one-cycle compression start pulse
- core_first_o  out  1  initialise h from parameter block (valid with start)
- core_last_o  out  1  final block flag (valid with start)
- core_t_o  out  64  byte counter (valid with start)
- core_done_i  in  1  one-cycle compression-complete pulse
- hash_idx_o  out  5  digest byte index into core
- hash_byte_i  in  8  digest byte at hash_idx_o (combinational from core)
- hash_v_o  out  1  digest byte valid
- hash_o  out  8  digest byte

Behaviour:
- Reset is synchronous and active-low on nreset, clocked by clk.
- Reset values:
  - state = IDLE, t = 0, msg_first = 1, err_o = 0.
  - All pulse outputs and hash_v_o = 0.
  - hash_o = 0, msg_idx_o = 0, msg_byte_o = 0.
- ll_total = ll_i + (kk_i != 0 ? 64 : 0), 64-bit with wrap; kk_i, nn_i and ll_i are stable during a message.
- Message byte writes:
  - In IDLE, data_v_i = 1 produces msg_we_o = 1 one cycle later, with msg_idx_o = data_idx_i and msg_byte_o = data_i (registered, 1-cycle latency).
  - Exception: when ll_total == 0, the byte is written as 0x00.
- Block end is detected on an accepted byte when either:
  - (a) data_idx_i == 63, or
  - (b) block_last_i = 1 and t + data_idx_i + 1 >= ll_total.
  - Case (b) with ll_total == 0 also ends the block on its first byte.
- On block end:
  - Latch core_last = (b), or (a) with block_last_i and t + 64 == ll_total.
  - If data_idx_i < 63, go to PAD; else go to START.
- PAD:
  - One zero write per cycle, msg_idx_o = last idx+1 .. 63, ready_o = 0.
  - After the idx 63 write, go to START.
- START (1 cycle):
  - core_start_o = 1 and core_first_o = msg_first.
  - core_t_o = last ? ll_total : t + 64; t <= core_t_o.
  - msg_first <= 0; go to BUSY.
- BUSY:
  - Wait for core_done_i.
  - Then go to OUT if last, else IDLE.
  - core_done_i outside BUSY is ignored.
- OUT:
  - hash_idx_o counts 0..nn_i-1, one per cycle.
  - hash_v_o/hash_o registered, 1-cycle latency; exactly nn_i consecutive valid cycles.
  - After the final index: t <= 0, msg_first <= 1, go to IDLE.
  - nn_i == 0 is treated as 1.
- ready_o = 1 only in IDLE and not in the cycle a block end is accepted.
- A byte with data_v_i = 1 while ready_o = 0 is dropped and sets err_o; err_o clears only on reset.
- Reset in any state aborts immediately: no pad writes, start pulses or hash bytes follow.

Test Plan:
- Single block: kk=0, nn=32, ll=3, bytes 0x61,0x62,0x63 at idx 0..2 with block_last -> 3 writes, then 61 zero writes idx 3..63; start with first=1, last=1, t=3; done -> 32 hash_v cycles, hash_idx 0..31.
- Two blocks: ll=65, 64 bytes, then 1 byte with block_last -> start#1 first=1, last=0, t=64; start#2 first=0, last=1, t=65, pad idx 1..63.
- Keyed, empty message: kk=16, ll=0, 64 key bytes with block_last -> no pad, start first=1, last=1, t=64.
- Unkeyed, empty message: kk=0, ll=0, one byte 0xAA with block_last -> write 0x00 at idx 0, pad 1..63, start t=0, last=1.
- Overrun: send byte during BUSY -> byte dropped, no msg_we, err_o=1 and held; nn=1 output -> single hash_v pulse.
- Reset mid-BUSY, then core_done_i pulse -> no hash_v; next message starts with first=1, t fresh.

Source files
------------

// File: rtl/blake2_block_ctrl_if.sv
// blake2_block_ctrl_if: controller bus; byte stream in (kk/nn/ll, data, idx, block flags, ready/err), core message writes, start/first/last/t, done, digest index/byte and digest stream out
interface blake2_block_ctrl_if;
  logic [5:0]  kk_i;
  logic [5:0]  nn_i;
  logic [63:0] ll_i;
  logic        data_v_i;
  logic [7:0]  data_i;
  logic [5:0]  data_idx_i;
  logic        block_first_i;
  logic        block_last_i;
  logic        ready_o;
  logic        err_o;
  logic        msg_we_o;
  logic [5:0]  msg_idx_o;
  logic [7:0]  msg_byte_o;
  logic        core_start_o;
  logic        core_first_o;
  logic        core_last_o;
  logic [63:0] core_t_o;
  logic        core_done_i;
  logic [4:0]  hash_idx_o;
  logic [7:0]  hash_byte_i;
  logic        hash_v_o;
  logic [7:0]  hash_o;
  modport slave (
    input  kk_i, nn_i, ll_i, data_v_i, data_i, data_idx_i, block_first_i, block_last_i, core_done_i, hash_byte_i,
    output ready_o, err_o, msg_we_o, msg_idx_o, msg_byte_o, core_start_o, core_first_o, core_last_o, core_t_o,
           hash_idx_o, hash_v_o, hash_o
  );
  modport master (
    output kk_i, nn_i, ll_i, data_v_i, data_i, data_idx_i, block_first_i, block_last_i, core_done_i, hash_byte_i,
    input  ready_o, err_o, msg_we_o, msg_idx_o, msg_byte_o, core_start_o, core_first_o, core_last_o, core_t_o,
           hash_idx_o, hash_v_o, hash_o
  );
endinterface

// File: rtl/blake2_block_ctrl.sv
// blake2_block_ctrl: BLAKE2s block sequencer; ports clk, nreset (sync active-low), bus (slave: message bytes in, core buffer writes + start/first/last/t, done in, digest bytes out)
module blake2_block_ctrl #(
  parameter int BB = 64,
  parameter int HB = 32
) (
  input logic clk,
  input logic nreset,
  blake2_block_ctrl_if.slave bus
);
  localparam int IW = $clog2(BB);
  localparam int HW = $clog2(HB);
  typedef enum logic [2:0] {IDLE, PAD, START, BUSY, OUT} state_t;
  state_t state, state_n;
  logic [63:0] t, ll_total, t_next;
  logic msg_first, last_q, accept, end_a, end_b, blk_end, last_n, pad_done, hash_done;
  logic [IW-1:0] pad_idx;
  logic [HW-1:0] hash_idx, hash_last;
  assign ll_total = bus.ll_i + (bus.kk_i != '0 ? 64'(BB) : 64'd0);
  assign accept = state == IDLE && bus.data_v_i;
  assign end_a = bus.data_idx_i == IW'(BB - 1);
  assign end_b = bus.block_last_i && t + 64'(bus.data_idx_i) + 64'd1 >= ll_total;
  assign blk_end = accept && (end_a || end_b);
  assign last_n = end_b || (end_a && bus.block_last_i && t + 64'(BB) == ll_total);
  assign t_next = last_q ? ll_total : t + 64'(BB);
  assign pad_done = pad_idx == IW'(BB - 1);
  assign hash_last = bus.nn_i == '0 ? '0 : HW'(bus.nn_i - 6'd1);
  assign hash_done = hash_idx == hash_last;
  assign bus.ready_o = state == IDLE && !blk_end;
  assign bus.core_start_o = state == START;
  assign bus.core_first_o = state == START && msg_first;
  assign bus.core_last_o = state == START && last_q;
  assign bus.core_t_o = t_next;
  assign bus.hash_idx_o = hash_idx;
  always_ff @(posedge clk) state <= !nreset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE && blk_end ? (end_a ? START : PAD) :
              state == PAD && pad_done ? START :
              state == START ? BUSY :
              state == BUSY && bus.core_done_i ? (last_q ? OUT : IDLE) :
              state == OUT && hash_done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      t <= '0;
      msg_first <= 1'b1;
      last_q <= 1'b0;
      pad_idx <= '0;
      hash_idx <= '0;
      bus.err_o <= 1'b0;
      bus.msg_we_o <= 1'b0;
      bus.msg_idx_o <= '0;
      bus.msg_byte_o <= '0;
      bus.hash_v_o <= 1'b0;
      bus.hash_o <= '0;
    end else begin
      bus.msg_we_o <= accept || state == PAD;
      if (accept) begin
        bus.msg_idx_o <= bus.data_idx_i;
        bus.msg_byte_o <= ll_total == '0 ? 8'h00 : bus.data_i;
      end else if (state == PAD) begin
        bus.msg_idx_o <= pad_idx;
        bus.msg_byte_o <= 8'h00;
      end
      if (blk_end) last_q <= last_n;
      pad_idx <= blk_end ? bus.data_idx_i + IW'(1) : state == PAD ? pad_idx + IW'(1) : pad_idx;
      if (bus.data_v_i && state != IDLE) bus.err_o <= 1'b1;
      bus.hash_v_o <= state == OUT;
      if (state == OUT) begin
        bus.hash_o <= bus.hash_byte_i;
        hash_idx <= hash_done ? '0 : hash_idx + HW'(1);
      end
      if (state == START) begin
        t <= t_next;
        msg_first <= 1'b0;
      end else if (state == OUT && hash_done) begin
        t <= '0;
        msg_first <= 1'b1;
      end
    end
  end
endmodule
